// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station.
package alu_rs_pkg;

    localparam int DATA_W    = 32;
    localparam int ALU_OP_W  = 4;
    // Tags are held at this width internally; narrower TAG_W values are zero-extended.
    localparam int TAG_MAX_W = 32;

    typedef logic [TAG_MAX_W-1:0] tag_t;

    // One reservation-station entry: op payload plus per-operand wakeup state.
    typedef struct packed {
        logic                valid;
        logic [ALU_OP_W-1:0] op;
        logic [DATA_W-1:0]   a_val;
        logic [DATA_W-1:0]   b_val;
        tag_t                a_tag;
        tag_t                b_tag;
        logic                a_rdy;
        logic                b_rdy;
        tag_t                dest;
        logic                regwrite;
    } rs_entry_t;

    // An entry may be dispatched once it is occupied and both operands are present.
    function automatic logic entry_ready(input rs_entry_t e);
        return e.valid && e.a_rdy && e.b_rdy;
    endfunction

endpackage

// File: rtl/rs_operand_snoop.sv
// Tag compare of one pending operand against both result buses; bus 0 has priority.
module rs_operand_snoop
    import alu_rs_pkg::*;
(
    input  logic              i_wait,
    input  tag_t              i_tag,
    input  tag_t              i_b0_dest,
    input  logic [DATA_W-1:0] i_b0_data,
    input  logic              i_b0_we,
    input  tag_t              i_b1_dest,
    input  logic [DATA_W-1:0] i_b1_data,
    input  logic              i_b1_we,
    output logic              o_cap,
    output logic [DATA_W-1:0] o_data
);

    logic w_hit0;
    logic w_hit1;

    assign w_hit0 = i_wait && i_b0_we && (i_tag == i_b0_dest);
    assign w_hit1 = i_wait && i_b1_we && (i_tag == i_b1_dest);
    assign o_cap  = w_hit0 || w_hit1;
    assign o_data = w_hit0 ? i_b0_data : i_b1_data;

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station for one ALU lane: collapsing queue with result-bus wakeup
// and a registered dispatch slot. Entry 0 is always the oldest op.
module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Flush,
    input  logic                IValid,
    input  logic [ALU_OP_W-1:0] IALUControl,
    input  logic [DATA_W-1:0]   ISrcA,
    input  logic [DATA_W-1:0]   ISrcB,
    input  logic [TAG_W-1:0]    ITagA,
    input  logic [TAG_W-1:0]    ITagB,
    input  logic                IRdyA,
    input  logic                IRdyB,
    input  logic [TAG_W-1:0]    IDest,
    input  logic                IRegWrite,
    output logic                IFull,
    output logic [CNT_W-1:0]    Count,
    input  logic [TAG_W-1:0]    B0Dest,
    input  logic [DATA_W-1:0]   B0Data,
    input  logic                B0RegWrite,
    input  logic [TAG_W-1:0]    B1Dest,
    input  logic [DATA_W-1:0]   B1Data,
    input  logic                B1RegWrite,
    output logic                DValid,
    input  logic                DReady,
    output logic [ALU_OP_W-1:0] DALUControl,
    output logic [DATA_W-1:0]   DSrcA,
    output logic [DATA_W-1:0]   DSrcB,
    output logic [TAG_W-1:0]    DDest,
    output logic                DRegWrite
);

    localparam int IDX_W = $clog2(DEPTH);

    // Handshake: the slot presents an op while DValid=1; it is consumed on a rising
    // edge where DValid=1 and DReady=1, and holds every D* value stable otherwise.
    // Issue side has no ready: an op is taken when IValid=1 and IFull=0, else dropped.

    rs_entry_t            r_q [DEPTH];
    logic [CNT_W-1:0]     r_count;
    logic                 r_full;
    logic                 r_dvalid;
    logic [ALU_OP_W-1:0]  r_d_op;
    logic [DATA_W-1:0]    r_d_a;
    logic [DATA_W-1:0]    r_d_b;
    logic [TAG_W-1:0]     r_d_dest;
    logic                 r_d_rw;

    tag_t                 w_b0_dest;
    tag_t                 w_b1_dest;
    logic [DEPTH-1:0]     w_cap_a;
    logic [DEPTH-1:0]     w_cap_b;
    logic [DATA_W-1:0]    w_dat_a [DEPTH];
    logic [DATA_W-1:0]    w_dat_b [DEPTH];
    logic                 w_iss_cap_a;
    logic                 w_iss_cap_b;
    logic [DATA_W-1:0]    w_iss_dat_a;
    logic [DATA_W-1:0]    w_iss_dat_b;
    rs_entry_t            w_snoop [DEPTH+1];
    rs_entry_t            w_issue;
    rs_entry_t            w_next [DEPTH];
    logic                 w_sel_found;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_load;
    logic                 w_accept;
    logic [CNT_W-1:0]     w_cnt_rem;
    logic [CNT_W-1:0]     w_cnt_next;

    assign w_b0_dest = tag_t'(B0Dest);
    assign w_b1_dest = tag_t'(B1Dest);

    // Wakeup comparators for every stored operand.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry_snoop
        rs_operand_snoop u_snoop_a (
            .i_wait    (r_q[g].valid && !r_q[g].a_rdy),
            .i_tag     (r_q[g].a_tag),
            .i_b0_dest (w_b0_dest),
            .i_b0_data (B0Data),
            .i_b0_we   (B0RegWrite),
            .i_b1_dest (w_b1_dest),
            .i_b1_data (B1Data),
            .i_b1_we   (B1RegWrite),
            .o_cap     (w_cap_a[g]),
            .o_data    (w_dat_a[g])
        );
        rs_operand_snoop u_snoop_b (
            .i_wait    (r_q[g].valid && !r_q[g].b_rdy),
            .i_tag     (r_q[g].b_tag),
            .i_b0_dest (w_b0_dest),
            .i_b0_data (B0Data),
            .i_b0_we   (B0RegWrite),
            .i_b1_dest (w_b1_dest),
            .i_b1_data (B1Data),
            .i_b1_we   (B1RegWrite),
            .o_cap     (w_cap_b[g]),
            .o_data    (w_dat_b[g])
        );
    end

    // Incoming issue operands see the same broadcasts as stored entries.
    rs_operand_snoop u_snoop_issue_a (
        .i_wait    (!IRdyA),
        .i_tag     (tag_t'(ITagA)),
        .i_b0_dest (w_b0_dest),
        .i_b0_data (B0Data),
        .i_b0_we   (B0RegWrite),
        .i_b1_dest (w_b1_dest),
        .i_b1_data (B1Data),
        .i_b1_we   (B1RegWrite),
        .o_cap     (w_iss_cap_a),
        .o_data    (w_iss_dat_a)
    );
    rs_operand_snoop u_snoop_issue_b (
        .i_wait    (!IRdyB),
        .i_tag     (tag_t'(ITagB)),
        .i_b0_dest (w_b0_dest),
        .i_b0_data (B0Data),
        .i_b0_we   (B0RegWrite),
        .i_b1_dest (w_b1_dest),
        .i_b1_data (B1Data),
        .i_b1_we   (B1RegWrite),
        .o_cap     (w_iss_cap_b),
        .o_data    (w_iss_dat_b)
    );

    // Apply this cycle's captures to the stored entries; the extra top slot feeds the collapse.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_snoop[i] = r_q[i];
            if (w_cap_a[i]) begin
                w_snoop[i].a_val = w_dat_a[i];
                w_snoop[i].a_rdy = 1'b1;
            end
            if (w_cap_b[i]) begin
                w_snoop[i].b_val = w_dat_b[i];
                w_snoop[i].b_rdy = 1'b1;
            end
        end
        w_snoop[DEPTH] = '0;
    end

    // Build the entry that an accepted issue writes, with same-cycle captures folded in.
    always_comb begin
        w_issue          = '0;
        w_issue.valid    = 1'b1;
        w_issue.op       = IALUControl;
        w_issue.a_val    = w_iss_cap_a ? w_iss_dat_a : ISrcA;
        w_issue.b_val    = w_iss_cap_b ? w_iss_dat_b : ISrcB;
        w_issue.a_tag    = tag_t'(ITagA);
        w_issue.b_tag    = tag_t'(ITagB);
        w_issue.a_rdy    = IRdyA || w_iss_cap_a;
        w_issue.b_rdy    = IRdyB || w_iss_cap_b;
        w_issue.dest     = tag_t'(IDest);
        w_issue.regwrite = IRegWrite;
    end

    // Oldest entry whose registered ready bits are both set.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_ready(r_q[i])) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    assign w_load     = w_sel_found && (!r_dvalid || DReady);
    assign w_accept   = IValid && !r_full;
    assign w_cnt_rem  = r_count - CNT_W'(w_load);
    assign w_cnt_next = w_cnt_rem + CNT_W'(w_accept);

    // Collapse over the removed entry, then append the new op at the first free index.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_load && (i >= int'(w_sel_idx))) begin
                w_next[i] = w_snoop[i+1];
            end else begin
                w_next[i] = w_snoop[i];
            end
            if (w_accept && (CNT_W'(i) == w_cnt_rem)) begin
                w_next[i] = w_issue;
            end
        end
    end

    // Queue storage and occupancy state.
    always_ff @(posedge CLK) begin
        if (!Reset || Flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_next[i];
            end
            r_count <= w_cnt_next;
            r_full  <= (w_cnt_next == CNT_W'(DEPTH));
        end
    end

    // Dispatch slot: load the selected entry when free or being consumed, else hold.
    always_ff @(posedge CLK) begin
        if (!Reset || Flush) begin
            r_dvalid <= 1'b0;
            r_d_op   <= '0;
            r_d_a    <= '0;
            r_d_b    <= '0;
            r_d_dest <= '0;
            r_d_rw   <= 1'b0;
        end else if (w_load) begin
            r_dvalid <= 1'b1;
            r_d_op   <= r_q[w_sel_idx].op;
            r_d_a    <= r_q[w_sel_idx].a_val;
            r_d_b    <= r_q[w_sel_idx].b_val;
            r_d_dest <= r_q[w_sel_idx].dest[TAG_W-1:0];
            r_d_rw   <= r_q[w_sel_idx].regwrite;
        end else if (DReady) begin
            r_dvalid <= 1'b0;
        end
    end

    assign IFull       = r_full;
    assign Count       = r_count;
    assign DValid      = r_dvalid;
    assign DALUControl = r_d_op;
    assign DSrcA       = r_d_a;
    assign DSrcB       = r_d_b;
    assign DDest       = r_d_dest;
    assign DRegWrite   = r_d_rw;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: hand-built vector table plus randomized traffic
// against a queue-based reference model.
module tb_alu_reservation_station;

    localparam int DEPTH = 4;
    localparam int TAG_W = 32;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ---------------- clock / reset / DUT ----------------
    logic              CLK = 1'b0;
    logic              Reset, Flush, IValid, IRdyA, IRdyB, IRegWrite;
    logic [3:0]        IALUControl;
    logic [31:0]       ISrcA, ISrcB;
    logic [TAG_W-1:0]  ITagA, ITagB, IDest, B0Dest, B1Dest;
    logic [31:0]       B0Data, B1Data;
    logic              B0RegWrite, B1RegWrite, DReady;
    logic              IFull, DValid, DRegWrite;
    logic [CNT_W-1:0]  Count;
    logic [3:0]        DALUControl;
    logic [31:0]       DSrcA, DSrcB;
    logic [TAG_W-1:0]  DDest;

    always #5 CLK = ~CLK;

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset), .Flush(Flush),
        .IValid(IValid), .IALUControl(IALUControl), .ISrcA(ISrcA), .ISrcB(ISrcB),
        .ITagA(ITagA), .ITagB(ITagB), .IRdyA(IRdyA), .IRdyB(IRdyB),
        .IDest(IDest), .IRegWrite(IRegWrite), .IFull(IFull), .Count(Count),
        .B0Dest(B0Dest), .B0Data(B0Data), .B0RegWrite(B0RegWrite),
        .B1Dest(B1Dest), .B1Data(B1Data), .B1RegWrite(B1RegWrite),
        .DValid(DValid), .DReady(DReady), .DALUControl(DALUControl),
        .DSrcA(DSrcA), .DSrcB(DSrcB), .DDest(DDest), .DRegWrite(DRegWrite)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, ta, tb, dest;
        bit          ra, rb, rw;
    } op_t;

    op_t m_q[$];
    op_t m_slot;
    bit  m_dv;
    bit  m_full;

    function automatic void m_snoop(inout bit rdy, inout logic [31:0] val, input logic [31:0] tag);
        if (rdy) return;
        if (B0RegWrite && B0Dest == tag) begin
            val = B0Data; rdy = 1'b1;
        end else if (B1RegWrite && B1Dest == tag) begin
            val = B1Data; rdy = 1'b1;
        end
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_step();
        int  sel;
        op_t e;
        if (!Reset || Flush) begin
            m_q.delete();
            m_dv   = 1'b0;
            m_full = 1'b0;
            m_slot = '{default: '0};
            return;
        end
        sel = -1;
        for (int i = 0; i < m_q.size(); i++)
            if (sel < 0 && m_q[i].ra && m_q[i].rb) sel = i;
        for (int i = 0; i < m_q.size(); i++) begin
            e = m_q[i];
            m_snoop(e.ra, e.a, e.ta);
            m_snoop(e.rb, e.b, e.tb);
            m_q[i] = e;
        end
        if (sel >= 0 && (!m_dv || DReady)) begin
            m_slot = m_q[sel];
            m_q.delete(sel);
            m_dv = 1'b1;
        end else if (DReady) begin
            m_dv = 1'b0;
        end
        if (IValid && !m_full) begin
            e.op = IALUControl; e.a = ISrcA; e.b = ISrcB; e.ta = ITagA; e.tb = ITagB;
            e.ra = IRdyA; e.rb = IRdyB; e.dest = IDest; e.rw = IRegWrite;
            m_snoop(e.ra, e.a, e.ta);
            m_snoop(e.rb, e.b, e.tb);
            m_q.push_back(e);
        end
        m_full = (m_q.size() == DEPTH);
    endfunction

    // ---------------- scoreboard ----------------
    logic [105:0] exp_q[$];

    task automatic check_model(input int cyc);
        logic [105:0] got, expv;
        exp_q.push_back({m_dv, CNT_W'(m_q.size()), m_full, m_slot.op, m_slot.a, m_slot.b,
                         m_slot.dest, m_slot.rw});
        expv = exp_q.pop_front();
        got  = {DValid, Count, IFull, DALUControl, DSrcA, DSrcB, DDest, DRegWrite};
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL model cyc=%0d got=%h exp=%h", cyc, got, expv);
        end
    endtask

    // ---------------- driver ----------------
    task automatic clear_inputs();
        Reset = 1'b1; Flush = 1'b0; IValid = 1'b0; IALUControl = '0;
        ISrcA = '0; ISrcB = '0; ITagA = '0; ITagB = '0; IRdyA = 1'b1; IRdyB = 1'b1;
        IDest = '0; IRegWrite = 1'b1;
        B0Dest = '0; B0Data = '0; B0RegWrite = 1'b0;
        B1Dest = '0; B1Data = '0; B1RegWrite = 1'b0; DReady = 1'b1;
    endtask

    int cyc = 0;

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        cyc++;
        check_model(cyc);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit rst_n, flush, iv;
        logic [3:0] op;
        logic [31:0] a, b;
        bit ra, rb;
        logic [31:0] ta, tb, dest, bd, b0x, b1x;
        bit b0we, b1we, dr;
        bit e_dv;
        int e_cnt;
        bit e_full;
        logic [31:0] e_a, e_b, e_d;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    initial begin
        // rst fl iv op a b ra rb ta tb dest | bd b0x b1x b0we b1we dr | dv cnt full a b dest
        // reset, then one fully-ready op
        add('{0,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,0,0,0,0,0});
        add('{0,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,0,0,0,0,0});
        add('{1,0,1,2,5,7,1,1,0,0,9,  0,0,0,0,0,1,  0,1,0,0,0,0});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  1,0,0,5,7,9});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,0,0,5,7,9});
        // wakeup on bus 1, tag 12
        add('{1,0,1,1,1,0,1,0,0,12,20, 0,0,0,0,0,1,  0,1,0,5,7,9});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,1,0,5,7,9});
        add('{1,0,0,0,0,0,1,1,0,0,0,  12,0,'h55,0,1,1, 0,1,0,5,7,9});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  1,0,0,1,'h55,20});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,0,0,1,'h55,20});
        // same-cycle capture, both buses hit tag 3: bus 0 wins
        add('{1,0,1,1,0,'h77,0,1,3,0,21, 3,'h11,'h22,1,1,1, 0,1,0,1,'h55,20});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  1,0,0,'h11,'h77,21});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,0,0,'h11,'h77,21});
        // matching tag without RegWrite never wakes the entry; flush clears it
        add('{1,0,1,1,2,0,1,0,0,12,22, 0,0,0,0,0,1,  0,1,0,'h11,'h77,21});
        add('{1,0,0,0,0,0,1,1,0,0,0,  12,0,'h66,0,0,1, 0,1,0,'h11,'h77,21});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,1,0,'h11,'h77,21});
        add('{1,1,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,0,0,0,0,0});
        // out-of-order readiness: oldest waits on tag 4
        add('{1,0,1,1,'h10,1,0,1,4,0,30, 0,0,0,0,0,1, 0,1,0,0,0,0});
        add('{1,0,1,1,'h21,'h22,1,1,0,0,31, 0,0,0,0,0,1, 0,2,0,0,0,0});
        add('{1,0,1,1,'h31,'h32,1,1,0,0,32, 0,0,0,0,0,1, 1,2,0,'h21,'h22,31});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  1,1,0,'h31,'h32,32});
        add('{1,0,0,0,0,0,1,1,0,0,0,  4,'h44,0,1,0,1, 0,1,0,'h31,'h32,32});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  1,0,0,'h44,1,30});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,0,0,'h44,1,30});
        // backpressure until full, overflow issue dropped, then drain in order
        add('{1,0,1,1,'h41,'h42,1,1,0,0,40, 0,0,0,0,0,0, 0,1,0,'h44,1,30});
        add('{1,0,1,1,'h51,'h52,1,1,0,0,41, 0,0,0,0,0,0, 1,1,0,'h41,'h42,40});
        add('{1,0,1,1,'h61,'h62,1,1,0,0,42, 0,0,0,0,0,0, 1,2,0,'h41,'h42,40});
        add('{1,0,1,1,'h71,'h72,1,1,0,0,43, 0,0,0,0,0,0, 1,3,0,'h41,'h42,40});
        add('{1,0,1,1,'h81,'h82,1,1,0,0,44, 0,0,0,0,0,0, 1,4,1,'h41,'h42,40});
        add('{1,0,1,1,'h91,'h92,1,1,0,0,45, 0,0,0,0,0,0, 1,4,1,'h41,'h42,40});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  1,3,0,'h51,'h52,41});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  1,2,0,'h61,'h62,42});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  1,1,0,'h71,'h72,43});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  1,0,0,'h81,'h82,44});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,0,0,'h81,'h82,44});
        // flush with entries and a held slot, issue in the flush cycle discarded
        add('{1,0,1,1,1,2,1,1,0,0,50, 0,0,0,0,0,0, 0,1,0,'h81,'h82,44});
        add('{1,0,1,1,3,4,1,1,0,0,51, 0,0,0,0,0,0, 1,1,0,1,2,50});
        add('{1,0,1,1,5,6,1,1,0,0,52, 0,0,0,0,0,0, 1,2,0,1,2,50});
        add('{1,0,1,1,7,8,1,1,0,0,53, 0,0,0,0,0,0, 1,3,0,1,2,50});
        add('{1,1,1,1,9,9,1,1,0,0,54, 0,0,0,0,0,0, 0,0,0,0,0,0});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,0,0,0,0,0});
        add('{1,0,0,0,0,0,1,1,0,0,0,  0,0,0,0,0,1,  0,0,0,0,0,0});
    end

    // ---------------- test sequence ----------------
    initial begin
        clear_inputs();
        #0;
        for (int r = 0; r < tbl.size(); r++) begin
            Reset = tbl[r].rst_n; Flush = tbl[r].flush; IValid = tbl[r].iv;
            IALUControl = tbl[r].op; ISrcA = tbl[r].a; ISrcB = tbl[r].b;
            IRdyA = tbl[r].ra; IRdyB = tbl[r].rb; ITagA = tbl[r].ta; ITagB = tbl[r].tb;
            IDest = tbl[r].dest; IRegWrite = 1'b1;
            B0Dest = tbl[r].bd; B1Dest = tbl[r].bd; B0Data = tbl[r].b0x; B1Data = tbl[r].b1x;
            B0RegWrite = tbl[r].b0we; B1RegWrite = tbl[r].b1we; DReady = tbl[r].dr;
            step();
            tests++;
            if (DValid !== tbl[r].e_dv || Count !== CNT_W'(tbl[r].e_cnt) || IFull !== tbl[r].e_full ||
                DSrcA !== tbl[r].e_a || DSrcB !== tbl[r].e_b || DDest !== tbl[r].e_d) begin
                fails++;
                $display("FAIL vec[%0d] got dv=%0b cnt=%0d full=%0b a=%h b=%h d=%h exp dv=%0b cnt=%0d full=%0b a=%h b=%h d=%h",
                         r, DValid, Count, IFull, DSrcA, DSrcB, DDest,
                         tbl[r].e_dv, tbl[r].e_cnt, tbl[r].e_full, tbl[r].e_a, tbl[r].e_b, tbl[r].e_d);
            end
        end

        // randomized traffic with small tag space so wakeups and bus collisions are common
        for (int c = 0; c < 3000; c++) begin
            Reset       = ($urandom_range(0, 299) != 0);
            Flush       = ($urandom_range(0, 79) == 0);
            IValid      = ($urandom_range(0, 2) != 0);
            IALUControl = 4'($urandom_range(0, 15));
            ISrcA       = $urandom;
            ISrcB       = $urandom;
            IRdyA       = ($urandom_range(0, 2) != 0);
            IRdyB       = ($urandom_range(0, 2) != 0);
            ITagA       = $urandom_range(0, 5);
            ITagB       = $urandom_range(0, 5);
            IDest       = $urandom_range(0, 5);
            IRegWrite   = 1'($urandom_range(0, 1));
            B0Dest      = $urandom_range(0, 5);
            B1Dest      = $urandom_range(0, 5);
            B0Data      = $urandom;
            B1Data      = $urandom;
            B0RegWrite  = 1'($urandom_range(0, 1));
            B1RegWrite  = 1'($urandom_range(0, 1));
            DReady      = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
